// File: rtl/da_pixel_sequencer.sv
// da_pixel_sequencer: walks an MxN window, sequencing operand fetch, MSB-first bit-planes, SA drain and result handshake.
// Define DA_SEQ_STALL_CNT_EN to add the saturating stall_cnt output.
module da_pixel_sequencer #(
  parameter int DATA_WIDTH_A = 16,
  parameter int M = 9,
  parameter int N = 9,
  parameter int SA_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic gen_req,
  input  logic gen_ready,
  output logic gen_done,
  output logic [7:0] t,
  output logic sa_clr,
  output logic sa_sub,
  output logic out_valid,
  input  logic out_ready,
  output logic [(M > 1 ? $clog2(M) : 1)-1:0] out_row,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0] out_col,
  output logic busy,
  output logic done
`ifdef DA_SEQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  localparam int RW = M > 1 ? $clog2(M) : 1;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int SW = SA_LAT > 1 ? $clog2(SA_LAT) : 1;
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, WAIT_GEN = 3'd2, ACCUM = 3'd3,
                         DRAIN = 3'd4, OUT = 3'd5, FIN = 3'd6;
  localparam logic [7:0] T_TOP = 8'(DATA_WIDTH_A - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
  localparam logic [SW-1:0] CNT_TOP = SW'(SA_LAT - 1);
  logic [2:0] state, nxt;
  logic [7:0] t_nxt;
  logic [SW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] row_nxt;
  logic [CW-1:0] col_nxt;
  logic last_pix;
  assign last_pix = (out_row == ROW_LAST) && (out_col == COL_LAST);
  always_comb begin
    nxt = state;
    t_nxt = '0;
    cnt_nxt = cnt;
    row_nxt = out_row;
    col_nxt = out_col;
    case (state)
      IDLE: if (start) begin
        nxt = REQ;
        row_nxt = '0;
        col_nxt = '0;
      end
      REQ: nxt = WAIT_GEN;
      WAIT_GEN: if (gen_ready) begin
        nxt = ACCUM;
        t_nxt = T_TOP;
      end
      ACCUM: if (t == 8'd0) begin
        nxt = DRAIN;
        cnt_nxt = CNT_TOP;
      end else t_nxt = t - 8'd1;
      DRAIN: if (cnt == '0) nxt = OUT; else cnt_nxt = cnt - 1'b1;
      OUT: if (out_ready) begin
        nxt = last_pix ? FIN : REQ;
        col_nxt = last_pix ? out_col : (out_col == COL_LAST ? '0 : out_col + 1'b1);
        row_nxt = !last_pix && out_col == COL_LAST ? out_row + 1'b1 : out_row;
      end
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // abort wins over everything, including a same-cycle handshake
    if (abort) begin
      nxt = IDLE;
      t_nxt = '0;
      row_nxt = out_row;
      col_nxt = out_col;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      t <= '0;
      out_row <= '0;
      out_col <= '0;
      gen_req <= 1'b0;
      gen_done <= 1'b0;
      sa_clr <= 1'b0;
      sa_sub <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      t <= t_nxt;
      out_row <= row_nxt;
      out_col <= col_nxt;
      gen_req <= nxt == REQ;
      gen_done <= nxt == ACCUM;
      sa_clr <= nxt == ACCUM && t_nxt == T_TOP;
      sa_sub <= nxt == ACCUM && t_nxt == T_TOP;
      out_valid <= nxt == OUT;
      busy <= nxt != IDLE;
      done <= nxt == FIN;
    end
  end
`ifdef DA_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (state == IDLE && start && !abort) stall_cnt <= '0;
    else if (((state == WAIT_GEN && !gen_ready) || (state == OUT && !out_ready)) && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_da_pixel_sequencer.sv
// tb_da_pixel_sequencer: directed windows with a scoreboard monitor for results, done and bit-plane order.
module tb_da_pixel_sequencer;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, gen_ready = 1'b1, out_ready = 1'b1;
  logic gen_req, gen_done, sa_clr, sa_sub, out_valid, busy, done;
  logic [7:0] t;
  logic out_row, out_col;
`ifdef DA_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  da_pixel_sequencer #(.DATA_WIDTH_A(16), .M(2), .N(2), .SA_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gen_req(gen_req),
    .gen_ready(gen_ready), .gen_done(gen_done), .t(t), .sa_clr(sa_clr), .sa_sub(sa_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
`ifdef DA_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  typedef struct {int row; int col; int cyc;} pix_t;
  pix_t exp_q[$];
  int done_q[$];
  int cyc = 0, t0 = 0, n_chk = 0, n_fail = 0;
  int run = 0, exp_t = 0;
  logic gd_prev = 1'b0, ab_prev = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc - t0);
    end
  endfunction
  // monitor: cycle k of a window is the one where cyc - t0 == k
  always @(negedge clk) begin
    #1;
    if (gen_done) begin
      exp_t = gd_prev ? exp_t - 1 : 15;
      chk("t", int'(t), exp_t);
      chk("sa_clr", int'(sa_clr), int'(exp_t == 15));
      chk("sa_sub", int'(sa_sub), int'(exp_t == 15));
      run++;
    end else begin
      if (gd_prev && !ab_prev) chk("gen_done_run", run, 16);
      chk("t_idle", int'(t), 0);
      run = 0;
    end
    if (out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", int'(out_valid), 0);
      else begin
        chk("out_row", int'(out_row), exp_q[0].row);
        chk("out_col", int'(out_col), exp_q[0].col);
        if (out_ready) begin
          chk("out_cycle", cyc - t0, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("unexpected_done", int'(done), 0);
      else chk("done_cycle", cyc - t0, done_q.pop_front());
    end
    gd_prev = gen_done;
    ab_prev = abort;
  end
  task automatic go();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_to(input int k);
    while (cyc - t0 < k) @(negedge clk);
  endtask
  task automatic push_std();
    exp_q.push_back('{0, 0, 20});
    exp_q.push_back('{0, 1, 40});
    exp_q.push_back('{1, 0, 60});
    exp_q.push_back('{1, 1, 80});
    done_q.push_back(81);
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() > 0 || done_q.size() > 0); i++) @(negedge clk);
    chk("pending_expectations", exp_q.size() + done_q.size(), 0);
    exp_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    chk("busy_after_window", int'(busy), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({gen_req, gen_done, t, sa_clr, sa_sub, out_valid, out_row, out_col, busy, done}), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outputs", int'({gen_req, gen_done, t, sa_clr, sa_sub, out_valid, out_row, out_col, busy, done}), 0);
    push_std();
    go();
    chk("gen_req_pulse", int'(gen_req), 1);
    @(negedge clk);
    chk("gen_req_drop", int'(gen_req), 0);
    drain();
`ifdef DA_SEQ_STALL_CNT_EN
    chk("stall_cnt_free", int'(stall_cnt), 0);
`endif
    gen_ready = 1'b0;
    out_ready = 1'b0;
    exp_q.push_back('{0, 0, 28});
    exp_q.push_back('{0, 1, 48});
    exp_q.push_back('{1, 0, 68});
    exp_q.push_back('{1, 1, 88});
    done_q.push_back(89);
    go();
    wait_to(7);
    gen_ready = 1'b1;
    wait_to(25);
    chk("valid_under_backpressure", int'(out_valid), 1);
    wait_to(28);
    out_ready = 1'b1;
    drain();
`ifdef DA_SEQ_STALL_CNT_EN
    chk("stall_cnt", int'(stall_cnt), 8);
`endif
    exp_q.push_back('{0, 0, 20});
    go();
    wait_to(31);
    chk("t_before_abort", int'(t), 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_gen_done", int'(gen_done), 0);
    chk("abort_row_col", int'({out_row, out_col}), 1);
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", int'(busy), 0);
    drain();
    push_std();
    go();
    drain();
    push_std();
    go();
    wait_to(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    go();
    wait_to(19);
    chk("drain_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", int'({gen_req, gen_done, t, sa_clr, sa_sub, out_valid, out_row, out_col, busy, done}), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_std();
    go();
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
